math_divider_restoring: RTL and testbench

//   Sequential unsigned restoring divider: q = a / b, r = a % b, one quotient bit per clock.

---
 rtl/math_divider_restoring_pkg.sv | 21 ++
 rtl/math_divider_restoring_if.sv | 23 ++
 rtl/math_divider_restoring_step.sv | 22 ++
 rtl/math_divider_restoring.sv | 96 +++++++++
 tb/tb_math_divider_restoring.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/math_divider_restoring_pkg.sv
// Shared definitions for the sequential math blocks: FSM state encodings and
// the constant-function used to size iteration counters.
package math_divider_restoring_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Smallest w with 2**w >= v; loop form keeps it usable in constant context.
    function automatic int unsigned ceil_log2(input int unsigned v);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/math_divider_restoring_if.sv
// start/busy/done handshake plus operand and result buses of the divider.
interface math_divider_restoring_if #(parameter int N = 4);

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, q, r, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r, div_by_zero
    );

endinterface

// File: rtl/math_divider_restoring_step.sv
// One restoring-division iteration: shift next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it fits.
module math_divider_step #(
    parameter int N = 4
) (
    input  logic [N:0]   rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] b,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N:0] shifted;

    always_comb begin
        shifted = {rem_in[N-1:0], bit_in};
        // rem_in[N] set means the shifted value already exceeds any N-bit divisor.
        q_bit   = rem_in[N] | (shifted >= {1'b0, b});
        rem_out = q_bit ? (shifted - {1'b0, b}) : shifted;
    end

endmodule

// File: rtl/math_divider_restoring.sv
// Sequential unsigned restoring divider, one quotient bit per clock:
// q = a / b, r = a % b, with a forced all-ones quotient on divide-by-zero.
module math_divider_restoring
    import math_divider_restoring_pkg::*;
#(
    parameter int N = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    math_divider_restoring_if.slave bus
);

    localparam int unsigned CW = ceil_log2(N);

    state_t       state;
    logic [CW-1:0] cnt;
    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;
    logic [N-1:0] dvd;
    logic [N:0]   rem;
    logic [N:0]   rem_nxt;
    logic         q_bit;

    logic         busy_r;
    logic         done_r;
    logic [N-1:0] q_r;
    logic [N-1:0] r_r;
    logic         dz_r;

    math_divider_step #(.N(N)) u_step (
        .rem_in  (rem),
        .bit_in  (dvd[N-1]),
        .b       (b_reg),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // dvd doubles as the quotient register: dividend bits shift out the top
    // while quotient bits shift in at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            dvd    <= '0;
            rem    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            q_r    <= '0;
            r_r    <= '0;
            dz_r   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_reg  <= bus.a;
                        b_reg  <= bus.b;
                        dvd    <= bus.a;
                        rem    <= '0;
                        cnt    <= CW'(N - 1);
                        busy_r <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    rem <= rem_nxt;
                    dvd <= {dvd[N-2:0], q_bit};
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state  <= ST_DONE;
                        done_r <= 1'b1;
                        dz_r   <= (b_reg == '0);
                        q_r    <= (b_reg == '0) ? '1 : {dvd[N-2:0], q_bit};
                        r_r    <= (b_reg == '0) ? a_reg : rem_nxt[N-1:0];
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.q           = q_r;
    assign bus.r           = r_r;
    assign bus.div_by_zero = dz_r;

endmodule

// File: tb/tb_math_divider_restoring.sv
// Directed self-checking bench for math_divider_restoring (N=4).
module tb_math_divider_restoring;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    math_divider_restoring_if #(.N(N)) bus ();

    math_divider_restoring #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one start, waits (bounded) for done, returns the result and the
    // number of cycles from the start edge to the done cycle, then moves to IDLE.
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                          output logic [3:0] qo, output logic [3:0] ro,
                          output logic dzo, output int lat);
        bus.a = av;
        bus.b = bv;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        qo  = bus.q;
        ro  = bus.r;
        dzo = bus.div_by_zero;
        step();
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({bus.busy, bus.done, bus.q, bus.r, bus.div_by_zero} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dz=%b, want all 0",
                     bus.busy, bus.done, bus.q, bus.r, bus.div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        n_cmp++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_timing();
        bus.a = 4'd13;
        bus.b = 4'd4;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            if (i > 1) step();
            n_cmp++;
            if (bus.busy !== (i <= 5)) begin
                n_fail++;
                $display("FAIL timing_busy cycle %0d: got %b want %b", i, bus.busy, (i <= 5));
            end
            n_cmp++;
            if (bus.done !== (i == 5)) begin
                n_fail++;
                $display("FAIL timing_done cycle %0d: got %b want %b", i, bus.done, (i == 5));
            end
            if (i == 5) begin
                n_cmp++;
                if ({bus.q, bus.r, bus.div_by_zero} !== {4'd3, 4'd1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL timing_result: got q=%0d r=%0d dz=%b want q=3 r=1 dz=0",
                             bus.q, bus.r, bus.div_by_zero);
                end
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [3:0] qo, ro, qe, re;
        logic       dzo, dze;
        int         lat;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                run_op(4'(ai), 4'(bi), qo, ro, dzo, lat);
                qe  = (bi == 0) ? 4'hF : 4'(ai / bi);
                re  = (bi == 0) ? 4'(ai) : 4'(ai % bi);
                dze = (bi == 0);
                n_cmp++;
                if ({qo, ro, dzo} !== {qe, re, dze}) begin
                    n_fail++;
                    $display("FAIL exh %0d/%0d: got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                             ai, bi, qo, ro, dzo, qe, re, dze);
                end
                n_cmp++;
                if (lat != 5) begin
                    n_fail++;
                    $display("FAIL exh_latency %0d/%0d: got %0d want 5", ai, bi, lat);
                end
            end
        end
    endtask

    task automatic test_div_zero();
        logic [3:0] qo, ro;
        logic       dzo;
        int         lat;
        run_op(4'd9, 4'd0, qo, ro, dzo, lat);
        n_cmp++;
        if ({qo, ro, dzo} !== {4'hF, 4'd9, 1'b1} || lat != 5) begin
            n_fail++;
            $display("FAIL div_zero: got q=%h r=%0d dz=%b lat=%0d want q=F r=9 dz=1 lat=5",
                     qo, ro, dzo, lat);
        end
        run_op(4'd9, 4'd3, qo, ro, dzo, lat);
        n_cmp++;
        if ({qo, ro, dzo} !== {4'd3, 4'd0, 1'b0} || lat != 5) begin
            n_fail++;
            $display("FAIL div_zero_clear: got q=%0d r=%0d dz=%b lat=%0d want q=3 r=0 dz=0 lat=5",
                     qo, ro, dzo, lat);
        end
    endtask

    task automatic test_start_during_run();
        int         n_done = 0;
        int         done_at = 0;
        logic [3:0] qo = '0;
        logic [3:0] ro = '0;
        bus.a = 4'd13;
        bus.b = 4'd4;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) step();
            if (i == 2) begin
                bus.a = 4'd1;
                bus.b = 4'd1;
                bus.start = 1'b1;
            end
            if (i == 3) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                n_done++;
                done_at = i;
                qo = bus.q;
                ro = bus.r;
            end
        end
        n_cmp++;
        if (n_done != 1 || done_at != 5) begin
            n_fail++;
            $display("FAIL ignore_start_pulses: got %0d done pulses last at %0d want 1 at 5",
                     n_done, done_at);
        end
        n_cmp++;
        if ({qo, ro} !== {4'd3, 4'd1}) begin
            n_fail++;
            $display("FAIL ignore_start_result: got q=%0d r=%0d want q=3 r=1", qo, ro);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_idle: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] qo, ro;
        logic       dzo;
        int         lat;
        int         n_done = 0;
        bus.a = 4'd13;
        bus.b = 4'd4;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.q, bus.r, bus.div_by_zero} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%b done=%b q=%h r=%h dz=%b want all 0",
                     bus.busy, bus.done, bus.q, bus.r, bus.div_by_zero);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.done === 1'b1) n_done++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.done === 1'b1) n_done++;
        end
        n_cmp++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d done pulses want 0", n_done);
        end
        run_op(4'd14, 4'd3, qo, ro, dzo, lat);
        n_cmp++;
        if ({qo, ro, dzo} !== {4'd4, 4'd2, 1'b0} || lat != 5) begin
            n_fail++;
            $display("FAIL reset_recover: got q=%0d r=%0d dz=%b lat=%0d want q=4 r=2 dz=0 lat=5",
                     qo, ro, dzo, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] qo, ro;
        logic       dzo;
        int         lat;
        run_op(4'd7, 4'd2, qo, ro, dzo, lat);
        n_cmp++;
        if ({qo, ro, dzo} !== {4'd3, 4'd1, 1'b0} || lat != 5) begin
            n_fail++;
            $display("FAIL b2b_first: got q=%0d r=%0d dz=%b lat=%0d want q=3 r=1 dz=0 lat=5",
                     qo, ro, dzo, lat);
        end
        run_op(4'd15, 4'd4, qo, ro, dzo, lat);
        n_cmp++;
        if ({qo, ro, dzo} !== {4'd3, 4'd3, 1'b0} || lat != 5) begin
            n_fail++;
            $display("FAIL b2b_second: got q=%0d r=%0d dz=%b lat=%0d want q=3 r=3 dz=0 lat=5",
                     qo, ro, dzo, lat);
        end
    endtask

    task automatic test_loopback();
        logic [3:0] fa [6] = '{4'd3, 4'd5, 4'd2, 4'd15, 4'd1, 4'd4};
        logic [3:0] fb [6] = '{4'd5, 4'd3, 4'd7, 4'd1, 4'd15, 4'd3};
        logic [3:0] p, qo, ro;
        logic       dzo;
        int         lat;
        for (int i = 0; i < 6; i++) begin
            p = 4'(fa[i] * fb[i]);
            run_op(p, fb[i], qo, ro, dzo, lat);
            n_cmp++;
            if ({qo, ro, dzo} !== {fa[i], 4'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL loopback %0d/%0d: got q=%0d r=%0d dz=%b want q=%0d r=0 dz=0",
                         p, fb[i], qo, ro, dzo, fa[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_exhaustive();
        test_div_zero();
        test_start_during_run();
        test_reset_mid_run();
        test_back_to_back();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
